dac_sweep_sequencer: RTL

Triangle-wave scan generator that drives the DAC AXI-Stream for PDH cavity/laser sweeps. It steps one selected DAC channel between programmable min and max codes at a programmable dwell rate. The other channel is held at a fixed code. Sits between the PS command decoder, which supplies latched config and start/stop pulses, and the DAC stream, in place of single-shot DAC writes.

---
 rtl/pdh_pkg.sv | 27 ++
 rtl/dwell_timer.sv | 45 ++++
 rtl/dac_sweep_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pdh_pkg.sv
// -----------------------------------------------------------------------------
// pdh_pkg
// Shared types and helpers for the PDH DAC sweep path.
//   sweep_state_t : sweep sequencer FSM states
//   pack_dac      : packs two DAC codes into one AXI-Stream word
//                   {2'b00, ch2[13:0], 2'b00, ch1[13:0]}
// -----------------------------------------------------------------------------
package pdh_pkg;

    localparam int DAC_DATA_WIDTH   = 14;
    localparam int AXIS_TDATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } sweep_state_t;

    function automatic logic [AXIS_TDATA_WIDTH-1:0] pack_dac(
        input logic [DAC_DATA_WIDTH-1:0] ch1,
        input logic [DAC_DATA_WIDTH-1:0] ch2
    );
        return {2'b00, ch2, 2'b00, ch1};
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Counts 0..limit while enabled and raises tick on the terminal count; the
// count then restarts at 0, so ticks are limit+1 cycles apart.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : latch load_value as the new limit and restart the count
//   load_value  : terminal count (extra cycles per level)
//   clr         : synchronous clear of the count
//   en          : count enable
//   tick        : terminal-count strobe (combinational from the count)
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clr,
    input  logic             en,
    output logic             tick
);

    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;

    assign tick = en && (count == limit);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit <= '0;
            count <= '0;
        end else if (load) begin
            limit <= load_value;
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dac_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// dac_sweep_sequencer
// Triangle-wave scan generator for the DAC AXI-Stream. One channel ramps
// between min and max in steps of step, each level held dwell+1 cycles; the
// other channel carries a fixed hold code. Runs a set number of periods
// (0 = until stopped).
//   clk, rst          : 125 MHz clock, asynchronous active-high reset
//   start_i, stop_i   : single-cycle start / abort pulses (stop wins)
//   cfg_*             : run configuration, latched on a valid start
//   dac_tdata_o       : packed two-channel DAC word
//   dac_tvalid_o      : one-cycle strobe per code update
//   busy_o, dir_o     : sweeping; ramp direction (1 = rising)
//   done_o, err_o     : normal completion; rejected start
//   cycle_cnt_o       : completed periods in the current run
// -----------------------------------------------------------------------------
module dac_sweep_sequencer
    import pdh_pkg::*;
#(
    parameter int DAC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DWELL_WIDTH      = 16,
    parameter int CYCLE_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic                        cfg_chan_i,
    input  logic [DAC_DATA_WIDTH-1:0]   cfg_min_i,
    input  logic [DAC_DATA_WIDTH-1:0]   cfg_max_i,
    input  logic [DAC_DATA_WIDTH-1:0]   cfg_step_i,
    input  logic [DWELL_WIDTH-1:0]      cfg_dwell_i,
    input  logic [CYCLE_WIDTH-1:0]      cfg_cycles_i,
    input  logic [DAC_DATA_WIDTH-1:0]   cfg_hold_i,
    output logic [AXIS_TDATA_WIDTH-1:0] dac_tdata_o,
    output logic                        dac_tvalid_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic                        dir_o,
    output logic [CYCLE_WIDTH-1:0]      cycle_cnt_o
);

    localparam int MSB = DAC_DATA_WIDTH - 1;

    sweep_state_t state_q, state_d;

    logic signed [MSB:0]        code_q, code_d;
    logic signed [MSB:0]        min_q, max_q;
    logic [MSB:0]               step_q, hold_q;
    logic                       chan_q;
    logic [CYCLE_WIDTH-1:0]     cycles_q;

    logic [CYCLE_WIDTH-1:0]     cycle_cnt_d, cnt_inc;
    logic                       dir_d, tvalid_d, done_d, err_d, busy_d;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_d;

    logic                       start_req, cfg_valid, start_ok, start_bad;
    logic                       tick;
    logic                       chan_sel;
    logic [MSB:0]               hold_sel;

    // One extra bit so code +/- step cannot wrap before the limit compare.
    logic signed [DAC_DATA_WIDTH:0] up_sum, dn_diff, min_ext, max_ext;

    assign start_req = start_i && !stop_i && (state_q == IDLE);
    assign cfg_valid = ($signed(cfg_min_i) < $signed(cfg_max_i)) && (cfg_step_i != '0);
    assign start_ok  = start_req && cfg_valid;
    assign start_bad = start_req && !cfg_valid;

    assign up_sum  = $signed({code_q[MSB], code_q}) + $signed({1'b0, step_q});
    assign dn_diff = $signed({code_q[MSB], code_q}) - $signed({1'b0, step_q});
    assign min_ext = $signed({min_q[MSB], min_q});
    assign max_ext = $signed({max_q[MSB], max_q});
    assign cnt_inc = cycle_cnt_o + CYCLE_WIDTH'(1);

    dwell_timer #(
        .WIDTH(DWELL_WIDTH)
    ) u_dwell (
        .clk       (clk),
        .rst       (rst),
        .load      (start_ok),
        .load_value(cfg_dwell_i),
        .clr       (stop_i),
        .en        ((state_q == UP) || (state_q == DOWN)),
        .tick      (tick)
    );

    // Run configuration, frozen for the whole run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q    <= '0;
            max_q    <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            chan_q   <= 1'b0;
            cycles_q <= '0;
        end else if (start_ok) begin
            min_q    <= cfg_min_i;
            max_q    <= cfg_max_i;
            step_q   <= cfg_step_i;
            hold_q   <= cfg_hold_i;
            chan_q   <= cfg_chan_i;
            cycles_q <= cfg_cycles_i;
        end
    end

    always_comb begin
        // NOTE: every combinationally driven signal gets a default first, so
        // no path through the case leaves it unassigned (no inferred latch).
        state_d     = state_q;
        code_d      = code_q;
        cycle_cnt_d = cycle_cnt_o;
        dir_d       = dir_o;
        tvalid_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = start_bad;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d     = UP;
                    code_d      = cfg_min_i;
                    cycle_cnt_d = '0;
                    dir_d       = 1'b1;
                    tvalid_d    = 1'b1;
                end
            end
            UP: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (tick) begin
                    tvalid_d = 1'b1;
                    if (up_sum >= max_ext) begin
                        code_d  = max_q;
                        state_d = DOWN;
                        dir_d   = 1'b0;
                    end else begin
                        code_d = up_sum[MSB:0];
                    end
                end
            end
            DOWN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (tick) begin
                    tvalid_d = 1'b1;
                    if (dn_diff <= min_ext) begin
                        code_d      = min_q;
                        cycle_cnt_d = cnt_inc;
                        if ((cycles_q != '0) && (cnt_inc == cycles_q)) begin
                            state_d = DONE;
                        end else begin
                            state_d = UP;
                            dir_d   = 1'b1;
                        end
                    end else begin
                        code_d = dn_diff[MSB:0];
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The start edge packs with the incoming cfg, later edges with the latched copy.
    assign chan_sel = start_ok ? cfg_chan_i : chan_q;
    assign hold_sel = start_ok ? cfg_hold_i : hold_q;
    assign busy_d   = (state_d == UP) || (state_d == DOWN);

    always_comb begin
        tdata_d = dac_tdata_o;
        if (tvalid_d) begin
            tdata_d = chan_sel ? pack_dac(hold_sel, code_d) : pack_dac(code_d, hold_sel);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            code_q       <= '0;
            cycle_cnt_o  <= '0;
            dir_o        <= 1'b0;
            dac_tvalid_o <= 1'b0;
            dac_tdata_o  <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            cycle_cnt_o  <= cycle_cnt_d;
            dir_o        <= dir_d;
            dac_tvalid_o <= tvalid_d;
            dac_tdata_o  <= tdata_d;
            done_o       <= done_d;
            err_o        <= err_d;
            busy_o       <= busy_d;
        end
    end

endmodule
